ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Receives PS/2 keyboard frames and turns them into the 2-bit key commands that drive the Tetris game controller.
//  Codes: 00 = up, 01 = left, 10 = right, 11 = enter.
//  Sits between the board PS/2 pins and the game logic, which consumes key_code qualified by key_valid.
//  Handles make/break/extended prefixes, parity and framing errors, and stalled frames.
// PARAMETERS
//  TIMEOUT_CYCLES  200000  clk cycles with no ps2_clk falling edge before a partial frame is abandoned (2 ms @ 100 MHz)
//  SYNC_STAGES     2       flip-flop stages on ps2_clk and ps2_data (minimum 2)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  reset, synchronous, active-high
//  ps2_clk        in   1  raw PS/2 clock pin, asynchronous, idle high
//  ps2_data       in   1  raw PS/2 data pin, asynchronous, idle high
//  key_code       out  2  last decoded command: 00 up, 01 left, 10 right, 11 enter
//  key_valid      out  1  one-clk pulse: key_code updated this cycle
//  rx_byte        out  8  last correctly received scan byte (debug)
//  rx_byte_valid  out  1  one-clk pulse when rx_byte updates
//  frame_err      out  1  one-clk pulse on a parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset:
//   - All outputs 0, FSM in IDLE, ext/brk flags 0.
//   - Synchroniser registers and previous-clock register load 1 (bus idle).
//  Input capture:
//   - Both pins pass through SYNC_STAGES flip-flops.
//   - fall = prev_clk & ~sync_clk. ps2_data is sampled only in fall cycles.
//  Frame FSM (advances only on fall):
//   - IDLE: data=0 -> DATA, bit count cleared. data=1 -> stay in IDLE (spurious edge, no error).
//   - DATA: shift in 8 bits LSB first. After bit 7 -> PARITY.
//   - PARITY: store bit, go to STOP.
//   - STOP: frame is good if stop=1 and (^byte ^ parity)=1 (odd parity). Always return to IDLE.
//  Good frame (the cycle after the stop-bit fall cycle):
//   - rx_byte <= byte and rx_byte_valid=1, then the byte goes to the decoder in that same cycle.
//  Bad frame:
//   - frame_err=1 for that cycle; byte discarded; ext and brk cleared.
//  Timeout:
//   - Counter clears on every fall and counts only while FSM != IDLE.
//   - At TIMEOUT_CYCLES-1: FSM -> IDLE, frame_err pulse, ext and brk cleared.
//  Decoder (per good byte):
//   - E0: set ext. F0: set brk. No other action for either.
//   - Any other byte: if brk=0, look it up. ext&75 -> 00; ext&6B -> 01; ext&74 -> 10; !ext&5A -> 11.
//   - A match gives key_code <= code and key_valid=1 in the same cycle as rx_byte_valid.
//   - Any non-prefix byte then clears ext and brk, matched or not.
//   - Break sequences (F0 xx, E0 F0 xx) never produce key_valid.
//   - Typematic repeats (repeated make codes) each produce a key_valid.
//  Latency: key_valid rises SYNC_STAGES+2 clk after the stop-bit falling edge at the pin.
//  key_code holds its value between pulses.
//  key_valid, rx_byte_valid and frame_err are never high for two consecutive cycles.
//  rst mid-frame: partial frame and flags discarded; the next complete frame decodes normally.
// TESTING
//  1. Frames E0, 75 -> exactly one key_valid; key_code=00; rx_byte_valid twice (E0, then 75).
//  2. Frames E0, 6B, then E0, F0, 6B -> one key_valid, key_code=01; no pulse for the break sequence.
//  3. 5A good, then 5A with parity flipped -> key_valid once, key_code=11; then frame_err pulse, no key_valid, key_code stays 11.
//  4. E0 good, then 4 bits of a frame, then idle > TIMEOUT_CYCLES -> frame_err once; then 74 alone -> no key_valid (ext was cleared).
//  5. rst asserted after 5 bits of a frame -> all outputs 0; then E0, 74 -> key_valid, key_code=10.
//  6. Frame 1C -> rx_byte=1C with rx_byte_valid; no key_valid; a frame with start bit 1 -> no pulses at all.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and decoder: turns make codes for the arrow and enter keys
// into 2-bit game commands (00 up, 01 left, 10 right, 11 enter).
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] key_code,
    output logic       key_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   prev_clk_reg;
    state_t                 state_reg;
    logic [2:0]             bit_cnt_reg;
    logic [7:0]             shift_reg;
    logic                   parity_reg;
    logic [CNT_W-1:0]       timeout_cnt_reg;
    logic                   good_reg;
    logic                   ext_reg;
    logic                   brk_reg;
    logic [1:0]             key_code_reg;
    logic                   key_valid_reg;
    logic [7:0]             rx_byte_reg;
    logic                   rx_byte_valid_reg;
    logic                   frame_err_reg;

    logic       sync_clk;
    logic       sync_data;
    logic       fall;
    logic       match;
    logic [1:0] code;

    assign sync_clk  = clk_sync_reg[SYNC_STAGES-1];
    assign sync_data = data_sync_reg[SYNC_STAGES-1];
    assign fall      = prev_clk_reg & ~sync_clk;

    // Lookup of the completed byte; only meaningful when good_reg is set.
    always_comb begin
        match = 1'b0;
        code  = 2'b00;
        if (ext_reg) begin
            case (shift_reg)
                8'h75:   begin match = 1'b1; code = 2'b00; end
                8'h6B:   begin match = 1'b1; code = 2'b01; end
                8'h74:   begin match = 1'b1; code = 2'b10; end
                default: begin match = 1'b0; code = 2'b00; end
            endcase
        end else if (shift_reg == 8'h5A) begin
            match = 1'b1;
            code  = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_reg      <= '1;
            data_sync_reg     <= '1;
            prev_clk_reg      <= 1'b1;
            state_reg         <= IDLE;
            bit_cnt_reg       <= 3'd0;
            shift_reg         <= 8'h00;
            parity_reg        <= 1'b0;
            timeout_cnt_reg   <= '0;
            good_reg          <= 1'b0;
            ext_reg           <= 1'b0;
            brk_reg           <= 1'b0;
            key_code_reg      <= 2'b00;
            key_valid_reg     <= 1'b0;
            rx_byte_reg       <= 8'h00;
            rx_byte_valid_reg <= 1'b0;
            frame_err_reg     <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
            prev_clk_reg  <= sync_clk;

            good_reg          <= 1'b0;
            key_valid_reg     <= 1'b0;
            rx_byte_valid_reg <= 1'b0;
            frame_err_reg     <= 1'b0;

            if (fall) begin
                timeout_cnt_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (!sync_data) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_reg   <= {sync_data, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7)
                            state_reg <= PARITY;
                    end
                    PARITY: begin
                        parity_reg <= sync_data;
                        state_reg  <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        if (sync_data && (^shift_reg ^ parity_reg)) begin
                            good_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                            ext_reg       <= 1'b0;
                            brk_reg       <= 1'b0;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end else if (state_reg != IDLE) begin
                // A stalled partial frame is dropped so the next start bit resyncs cleanly.
                if (timeout_cnt_reg == CNT_LAST) begin
                    state_reg       <= IDLE;
                    timeout_cnt_reg <= '0;
                    frame_err_reg   <= 1'b1;
                    ext_reg         <= 1'b0;
                    brk_reg         <= 1'b0;
                end else begin
                    timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
                end
            end

            // shift_reg is stable here: no new fall can arrive one cycle after the stop bit.
            if (good_reg) begin
                rx_byte_reg       <= shift_reg;
                rx_byte_valid_reg <= 1'b1;
                if (shift_reg == 8'hE0) begin
                    ext_reg <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk_reg <= 1'b1;
                end else begin
                    if (!brk_reg && match) begin
                        key_code_reg  <= code;
                        key_valid_reg <= 1'b1;
                    end
                    ext_reg <= 1'b0;
                    brk_reg <= 1'b0;
                end
            end
        end
    end

    assign key_code      = key_code_reg;
    assign key_valid     = key_valid_reg;
    assign rx_byte       = rx_byte_reg;
    assign rx_byte_valid = rx_byte_valid_reg;
    assign frame_err     = frame_err_reg;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames on the pins and checks
// pulse counts, decoded codes, latency, error handling and reset recovery.
module tb_ps2_key_decoder;
    localparam int TIMEOUT = 1000;
    localparam int SYNC    = 2;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] key_code;
    logic       key_valid;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_err;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int kv_cnt = 0, rx_cnt = 0, fe_cnt = 0, consec_cnt = 0;
    int kv_cyc = 0, fall_cyc = 0;
    logic kv_q = 1'b0, rx_q = 1'b0, fe_q = 1'b0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .key_valid(key_valid), .rx_byte(rx_byte),
        .rx_byte_valid(rx_byte_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (key_valid) begin kv_cnt <= kv_cnt + 1; kv_cyc <= cyc; end
        if (rx_byte_valid) rx_cnt <= rx_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if ((key_valid && kv_q) || (rx_byte_valid && rx_q) || (frame_err && fe_q))
            consec_cnt <= consec_cnt + 1;
        kv_q <= key_valid;
        rx_q <= rx_byte_valid;
        fe_q <= frame_err;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        wait_clks(HALF);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        wait_clks(HALF);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic start_bit);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, start_bit};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        wait_clks(40);
        $display("frame %h bad_par=%0b start=%0b -> key_code=%b rx_byte=%h kv=%0d rx=%0d fe=%0d",
                 b, bad_par, start_bit, key_code, rx_byte, kv_cnt, rx_cnt, fe_cnt);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        $display("partial frame %h, %0d bits", b, nbits);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(3);
        vectors++;
        if ({key_code, key_valid, rx_byte, rx_byte_valid, frame_err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {key_code, key_valid, rx_byte, rx_byte_valid, frame_err});
        end
        rst = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_up();
        int kv0, rx0, fe0;
        kv0 = kv_cnt; rx0 = rx_cnt; fe0 = fe_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        vectors++;
        if (rx_byte !== 8'hE0) begin
            errors++; $display("FAIL up_rx_e0: got %h expected e0", rx_byte);
        end
        send_frame(8'h75, 1'b0, 1'b0);
        check_int("up_kv_count", kv_cnt - kv0, 1);
        check_int("up_rx_count", rx_cnt - rx0, 2);
        check_int("up_fe_count", fe_cnt - fe0, 0);
        check_int("up_key_code", int'(key_code), 0);
        check_int("up_latency", kv_cyc - fall_cyc, SYNC + 2);
    endtask

    task automatic test_left_break();
        int kv0;
        kv0 = kv_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        check_int("left_kv_count", kv_cnt - kv0, 1);
        check_int("left_key_code", int'(key_code), 1);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        check_int("break_kv_count", kv_cnt - kv0, 1);
        check_int("break_key_code", int'(key_code), 1);
    endtask

    task automatic test_enter_parity();
        int kv0, rx0, fe0;
        kv0 = kv_cnt; rx0 = rx_cnt; fe0 = fe_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        check_int("enter_kv_count", kv_cnt - kv0, 1);
        check_int("enter_key_code", int'(key_code), 3);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_int("parity_fe_count", fe_cnt - fe0, 1);
        check_int("parity_kv_count", kv_cnt - kv0, 1);
        check_int("parity_rx_count", rx_cnt - rx0, 1);
        check_int("parity_key_code", int'(key_code), 3);
    endtask

    task automatic test_back_to_back();
        int kv0;
        kv0 = kv_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        check_int("typematic_kv_count", kv_cnt - kv0, 2);
    endtask

    task automatic test_timeout();
        int kv0, rx0, fe0;
        kv0 = kv_cnt; rx0 = rx_cnt; fe0 = fe_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_partial(8'h74, 4);
        wait_clks(TIMEOUT + 200);
        check_int("timeout_fe_count", fe_cnt - fe0, 1);
        send_frame(8'h74, 1'b0, 1'b0);
        check_int("timeout_kv_count", kv_cnt - kv0, 0);
        check_int("timeout_rx_count", rx_cnt - rx0, 2);
        check_int("timeout_rx_byte", int'(rx_byte), 8'h74);
        check_int("timeout_fe_total", fe_cnt - fe0, 1);
    endtask

    task automatic test_reset_mid_frame();
        int kv0;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_partial(8'h74, 5);
        rst = 1'b1;
        wait_clks(2);
        vectors++;
        if ({key_code, key_valid, rx_byte, rx_byte_valid, frame_err} !== 13'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 0",
                     {key_code, key_valid, rx_byte, rx_byte_valid, frame_err});
        end
        rst = 1'b0;
        wait_clks(5);
        kv0 = kv_cnt;
        send_frame(8'h74, 1'b0, 1'b0);
        check_int("midrst_no_ext_kv", kv_cnt - kv0, 0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        check_int("midrst_kv_count", kv_cnt - kv0, 1);
        check_int("midrst_key_code", int'(key_code), 2);
    endtask

    task automatic test_unmapped_and_spurious();
        int kv0, rx0, fe0;
        kv0 = kv_cnt; rx0 = rx_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b0);
        check_int("unmapped_rx_byte", int'(rx_byte), 8'h1C);
        check_int("unmapped_rx_count", rx_cnt - rx0, 1);
        check_int("unmapped_kv_count", kv_cnt - kv0, 0);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_clks(TIMEOUT + 100);
        check_int("spurious_rx_count", rx_cnt - rx0, 1);
        check_int("spurious_fe_count", fe_cnt - fe0, 0);
        check_int("spurious_kv_count", kv_cnt - kv0, 0);
        check_int("spurious_rx_byte", int'(rx_byte), 8'h1C);
    endtask

    initial begin
        test_reset();
        test_up();
        test_left_break();
        test_enter_parity();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        test_unmapped_and_spurious();
        check_int("no_consecutive_pulses", consec_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
